// File: rtl/uart_cmd_parser.sv
`timescale 1ns/1ps
// Purpose: parse HEADER,CMD,LEN,payload,CSUM byte frames from a UART receiver into commands.
// Latency: cmd_valid/frame_err pulse one cycle after the terminating byte is accepted.
// Backpressure: none; bytes are taken on the rising edge of uart_rx_done and never stalled.
// Optional: define UART_CMD_TIMEOUT_EN to abort frames after TIMEOUT_CYCLES of inter-byte silence.
module uart_cmd_parser #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         MAX_LEN        = 4,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_50m,
  input  logic        reset_n,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_done,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [2:0]  cmd_len,
  output logic [31:0] cmd_payload,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  // Reject configurations the 32-bit payload and 3-bit length cannot represent.
  if (MAX_LEN < 1 || MAX_LEN > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_cmd_parser: MAX_LEN must be 1..4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } state_t;

  state_t      state;
  state_t      state_nxt;
  state_t      eval_state;
  logic        done_q;
  logic        byte_acc;
  logic [7:0]  sum;
  logic [1:0]  idx;
  logic [2:0]  len_q;
  logic [7:0]  code_q;
  logic [31:0] pay_q;
  logic        to_hit;
  logic        start_frame;
  logic        ld_code;
  logic        ld_len;
  logic        ld_data;
  logic        set_valid;
  logic        set_err;
  logic        last_byte;

  // A held-high done level counts as a single byte.
  assign byte_acc  = uart_rx_done && !done_q;
  assign last_byte = ({1'b0, idx} == (len_q - 3'd1));

  // Register the done strobe for rising-edge detection.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= uart_rx_done;
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Count idle cycles inside a frame; any accepted byte restarts the count.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n)                                      to_cnt <= '0;
    else if (byte_acc || to_hit || state == ST_IDLE)   to_cnt <= '0;
    else                                               to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign to_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath controls; a timeout forces IDLE and the same-cycle byte is judged as in IDLE.
  always_comb begin
    state_nxt   = state;
    eval_state  = state;
    start_frame = 1'b0;
    ld_code     = 1'b0;
    ld_len      = 1'b0;
    ld_data     = 1'b0;
    set_valid   = 1'b0;
    set_err     = 1'b0;
    if (to_hit) begin
      eval_state = ST_IDLE;
      state_nxt  = ST_IDLE;
      set_err    = 1'b1;
    end
    if (byte_acc) begin
      case (eval_state)
        ST_IDLE: begin
          if (uart_rx_data == HEADER) begin
            start_frame = 1'b1;
            state_nxt   = ST_CMD;
          end
        end
        ST_CMD: begin
          ld_code   = 1'b1;
          state_nxt = ST_LEN;
        end
        ST_LEN: begin
          if (uart_rx_data > 8'(MAX_LEN)) begin
            set_err   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ld_len    = 1'b1;
            state_nxt = (uart_rx_data == 8'd0) ? ST_CSUM : ST_DATA;
          end
        end
        ST_DATA: begin
          ld_data = 1'b1;
          if (last_byte) state_nxt = ST_CSUM;
        end
        ST_CSUM: begin
          if (uart_rx_data == sum) set_valid = 1'b1;
          else                     set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Working frame: command, length, running sum and payload buffer.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      sum    <= 8'd0;
      idx    <= 2'd0;
      len_q  <= 3'd0;
      code_q <= 8'd0;
      pay_q  <= 32'd0;
    end else begin
      if (start_frame) begin
        pay_q <= 32'd0;
        idx   <= 2'd0;
      end
      if (ld_code) begin
        code_q <= uart_rx_data;
        sum    <= uart_rx_data;
      end
      if (ld_len) begin
        len_q <= uart_rx_data[2:0];
        sum   <= sum + uart_rx_data;
        idx   <= 2'd0;
      end
      if (ld_data) begin
        pay_q[{idx, 3'b000} +: 8] <= uart_rx_data;
        sum                       <= sum + uart_rx_data;
        idx                       <= idx + 2'd1;
      end
    end
  end

  // Result pulses, published command fields and saturating error count.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid   <= 1'b0;
      frame_err   <= 1'b0;
      cmd_code    <= 8'd0;
      cmd_len     <= 3'd0;
      cmd_payload <= 32'd0;
      err_cnt     <= 8'd0;
    end else begin
      cmd_valid <= set_valid;
      frame_err <= set_err;
      if (set_valid) begin
        cmd_code    <= code_q;
        cmd_len     <= len_q;
        cmd_payload <= pay_q;
      end
      if (set_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
`timescale 1ns/1ps
// Directed bench for uart_cmd_parser: frame table plus latency, timeout, reset and saturation sequences.
module tb_uart_cmd_parser;

  logic        clk_50m;
  logic        reset_n;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_done;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_payload;
  logic        frame_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;

  uart_cmd_parser dut (
    .clk_50m      (clk_50m),
    .reset_n      (reset_n),
    .uart_rx_data (uart_rx_data),
    .uart_rx_done (uart_rx_done),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_len      (cmd_len),
    .cmd_payload  (cmd_payload),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  // Pulses last one cycle, so sampling on the falling edge counts each once.
  always @(negedge clk_50m) begin
    if (cmd_valid) n_valid++;
    if (frame_err) n_err++;
    if (cmd_valid && frame_err) n_both++;
  end

  typedef struct {
    logic [63:0] bytes;   // first byte in the most significant used position
    int          n;
    int          hold;
    int          exp_v;
    int          exp_e;
    logic [7:0]  code;
    logic [2:0]  len;
    logic [31:0] pl;
    logic [7:0]  ec;
  } vec_t;

  function automatic vec_t mk(logic [63:0] b, int n, int hold, int v, int e,
                              logic [7:0] code, logic [2:0] len, logic [31:0] pl, logic [7:0] ec);
    vec_t r;
    r.bytes = b; r.n = n; r.hold = hold; r.exp_v = v; r.exp_e = e;
    r.code = code; r.len = len; r.pl = pl; r.ec = ec;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(logic [7:0] d, int hold);
    @(negedge clk_50m);
    uart_rx_data = d;
    uart_rx_done = 1'b1;
    repeat (hold) @(negedge clk_50m);
    uart_rx_done = 1'b0;
  endtask

  task automatic send_frame(logic [63:0] b, int n, int hold);
    logic [63:0] bb;
    bb = b;
    for (int i = 0; i < n; i++) send_byte(bb[8*(n-1-i) +: 8], hold);
  endtask

  vec_t vecs[9];
  int   v0, e0;

  initial begin
    reset_n      = 1'b0;
    uart_rx_data = 8'h00;
    uart_rx_done = 1'b0;
    repeat (3) @(negedge clk_50m);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_err",   32'(frame_err), 32'd0);
    chk("rst_code",  32'(cmd_code), 32'd0);
    chk("rst_len",   32'(cmd_len), 32'd0);
    chk("rst_pl",    cmd_payload, 32'd0);
    chk("rst_ecnt",  32'(err_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50m);

    vecs[0] = mk(64'hA51002341258, 6, 1,  1, 0, 8'h10, 3'd2, 32'h00001234, 8'd0);
    vecs[1] = mk(64'hA51002341259, 6, 1,  0, 1, 8'h10, 3'd2, 32'h00001234, 8'd1);
    vecs[2] = mk(64'hA52205,       3, 1,  0, 1, 8'h10, 3'd2, 32'h00001234, 8'd2);
    vecs[3] = mk(64'hA5010001,     4, 1,  1, 0, 8'h01, 3'd0, 32'h00000000, 8'd2);
    vecs[4] = mk(64'h00FFA5030003, 6, 10, 1, 0, 8'h03, 3'd0, 32'h00000000, 8'd2);
    vecs[5] = mk(64'hA5200411223344CE, 8, 1, 1, 0, 8'h20, 3'd4, 32'h44332211, 8'd2);
    vecs[6] = mk(64'hA53001A5D6,   5, 1,  1, 0, 8'h30, 3'd1, 32'h000000A5, 8'd2);
    vecs[7] = mk(64'hA5FF02809011, 6, 1,  1, 0, 8'hFF, 3'd2, 32'h00009080, 8'd2);
    vecs[8] = mk(64'hA5050006,     4, 1,  0, 1, 8'hFF, 3'd2, 32'h00009080, 8'd3);

    for (int k = 0; k < 9; k++) begin
      v0 = n_valid; e0 = n_err;
      send_frame(vecs[k].bytes, vecs[k].n, vecs[k].hold);
      repeat (3) @(negedge clk_50m);
      chk($sformatf("v%0d_valid", k), 32'(n_valid - v0), 32'(vecs[k].exp_v));
      chk($sformatf("v%0d_err",   k), 32'(n_err - e0),   32'(vecs[k].exp_e));
      chk($sformatf("v%0d_code",  k), 32'(cmd_code),     32'(vecs[k].code));
      chk($sformatf("v%0d_len",   k), 32'(cmd_len),      32'(vecs[k].len));
      chk($sformatf("v%0d_pl",    k), cmd_payload,       vecs[k].pl);
      chk($sformatf("v%0d_ecnt",  k), 32'(err_cnt),      32'(vecs[k].ec));
    end

    // Pulse timing: asserted right after the accepting edge of the last byte, gone one edge later.
    send_frame(64'hA50100, 3, 1);
    @(negedge clk_50m);
    uart_rx_data = 8'h01;
    uart_rx_done = 1'b1;
    @(posedge clk_50m); #1;
    chk("lat_valid_on", 32'(cmd_valid), 32'd1);
    chk("lat_err_off",  32'(frame_err), 32'd0);
    @(posedge clk_50m); #1;
    chk("lat_valid_off", 32'(cmd_valid), 32'd0);
    @(negedge clk_50m);
    uart_rx_done = 1'b0;
    repeat (3) @(negedge clk_50m);

    // Inter-byte silence inside a frame.
    v0 = n_valid; e0 = n_err;
    send_frame(64'hA507, 2, 1);
    repeat (50010) @(negedge clk_50m);
`ifdef UART_CMD_TIMEOUT_EN
    chk("to_err", 32'(n_err - e0), 32'd1);
    chk("to_ecnt", 32'(err_cnt), 32'd4);
    send_frame(64'hA5070007, 4, 1);
`else
    chk("to_err", 32'(n_err - e0), 32'd0);
    chk("to_ecnt", 32'(err_cnt), 32'd3);
    send_frame(64'h0007, 2, 1);
`endif
    repeat (3) @(negedge clk_50m);
    chk("to_valid", 32'(n_valid - v0), 32'd1);
    chk("to_code",  32'(cmd_code), 32'h07);

    // Reset in the middle of a frame aborts it silently.
    v0 = n_valid; e0 = n_err;
    send_frame(64'hA510, 2, 1);
    @(negedge clk_50m);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_50m);
    chk("mrst_code", 32'(cmd_code), 32'd0);
    chk("mrst_ecnt", 32'(err_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_50m);
    chk("mrst_pulses", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
    send_frame(64'hA5100010, 4, 1);
    repeat (3) @(negedge clk_50m);
    chk("mrst_valid", 32'(n_valid - v0), 32'd1);
    chk("mrst_err",   32'(n_err - e0), 32'd0);
    chk("mrst_code2", 32'(cmd_code), 32'h10);

    // Error counter saturation.
    e0 = n_err;
    for (int k = 0; k < 300; k++) send_frame(64'hA52205, 3, 1);
    repeat (3) @(negedge clk_50m);
    chk("sat_pulses", 32'(n_err - e0), 32'd300);
    chk("sat_ecnt",   32'(err_cnt), 32'hFF);

    chk("never_both", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
